// File: rtl/divmodule.sv
// divmodule: 8-bit restoring divider, one quotient bit per CALC cycle.
// Define DIV_SIGNED_EN to add the SIGNED port and the FIX sign stage.
module divmodule (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] DATA1,
    input  logic [7:0] DATA2,
`ifdef DIV_SIGNED_EN
    input  logic       SIGNED,
`endif
    output logic [7:0] QUOTIENT,
    output logic [7:0] REMAINDER,
    output logic       BUSY,
    output logic       DONE,
    output logic       DIVZERO
);

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {IDLE, CALC, FIX, FINISH} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
`endif

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic [7:0] r_dvd;
    logic [7:0] r_dvs;
    logic [7:0] r_quo;
    logic [7:0] r_rem;
    logic [7:0] r_quotient;
    logic [7:0] r_remainder;
    logic       r_busy;
    logic       r_done;
    logic       r_divzero;
    logic       w_last;
    logic       w_zero;
    logic       w_ge;
    logic       w_sgn;
    logic [8:0] w_shift;
    logic [7:0] w_rem_nxt;
    logic [7:0] w_mag1;
    logic [7:0] w_mag2;

`ifdef DIV_SIGNED_EN
    logic r_sgn;
    logic r_neg1;
    logic r_neg2;
    logic w_neg1;
    logic w_neg2;

    assign w_neg1 = SIGNED & DATA1[7];
    assign w_neg2 = SIGNED & DATA2[7];
    assign w_mag1 = w_neg1 ? 8'(-DATA1) : DATA1;
    assign w_mag2 = w_neg2 ? 8'(-DATA2) : DATA2;
    assign w_sgn  = r_sgn;
`else
    assign w_mag1 = DATA1;
    assign w_mag2 = DATA2;
    assign w_sgn  = 1'b0;
`endif

    // Partial remainder shifted left with the next dividend bit, then trial subtract.
    assign w_shift   = {r_rem, r_quo[7]};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    assign w_rem_nxt = w_ge ? 8'(w_shift - {1'b0, r_dvs}) : w_shift[7:0];
    assign w_zero    = (r_dvs == 8'd0);
    assign w_last    = (r_cnt == 4'd8);

    assign QUOTIENT  = r_quotient;
    assign REMAINDER = r_remainder;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign DIVZERO   = r_divzero;

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; START only counts in IDLE or FINISH.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (START) w_next = CALC;
            end
            CALC: begin
                if (w_zero) begin
                    w_next = FINISH;
                end else if (w_last) begin
`ifdef DIV_SIGNED_EN
                    w_next = w_sgn ? FIX : FINISH;
`else
                    w_next = FINISH;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            FIX: w_next = FINISH;
`endif
            FINISH: w_next = START ? CALC : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and registered results.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt       <= 4'd0;
            r_dvd       <= 8'd0;
            r_dvs       <= 8'd0;
            r_quo       <= 8'd0;
            r_rem       <= 8'd0;
            r_quotient  <= 8'd0;
            r_remainder <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_divzero   <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_sgn       <= 1'b0;
            r_neg1      <= 1'b0;
            r_neg2      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE, FINISH: begin
                    if (START) begin
                        r_dvd  <= DATA1;
                        r_dvs  <= w_mag2;
                        r_quo  <= w_mag1;
                        r_rem  <= 8'd0;
                        r_cnt  <= 4'd0;
                        r_busy <= 1'b1;
                        if (DATA2 != 8'd0) r_divzero <= 1'b0;
`ifdef DIV_SIGNED_EN
                        r_sgn  <= SIGNED;
                        r_neg1 <= w_neg1;
                        r_neg2 <= w_neg2;
`endif
                    end
                end
                CALC: begin
                    if (w_zero) begin
                        r_quotient  <= 8'hFF;
                        r_remainder <= r_dvd;
                        r_divzero   <= 1'b1;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (!w_last) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= {r_quo[6:0], w_ge};
                        r_cnt <= r_cnt + 4'd1;
                    end else if (!w_sgn) begin
                        r_quotient  <= r_quo;
                        r_remainder <= r_rem;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
`ifdef DIV_SIGNED_EN
                // Quotient sign is the XOR of operand signs; remainder follows dividend.
                FIX: begin
                    r_quotient  <= (r_neg1 ^ r_neg2) ? 8'(-r_quo) : r_quo;
                    r_remainder <= r_neg1 ? 8'(-r_rem) : r_rem;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divmodule.sv
// tb_divmodule: directed scoreboard bench for divmodule.
// Signed cases are exercised when DIV_SIGNED_EN is defined.
module tb_divmodule;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [7:0] DATA1 = 8'd0;
    logic [7:0] DATA2 = 8'd0;
`ifdef DIV_SIGNED_EN
    logic       SIGNED = 1'b0;
`endif
    logic [7:0] QUOTIENT;
    logic [7:0] REMAINDER;
    logic       BUSY;
    logic       DONE;
    logic       DIVZERO;

    int n_run   = 0;
    int n_fail  = 0;
    int t_since = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    divmodule dut (
        .CLK(CLK),
        .RESET(RESET),
        .START(START),
        .DATA1(DATA1),
        .DATA2(DATA2),
`ifdef DIV_SIGNED_EN
        .SIGNED(SIGNED),
`endif
        .QUOTIENT(QUOTIENT),
        .REMAINDER(REMAINDER),
        .BUSY(BUSY),
        .DONE(DONE),
        .DIVZERO(DIVZERO)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
        t_since++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input int elat);
        exp_t e;
        e.q = eq;
        e.r = er;
        e.dz = edz;
        e.lat = elat;
        sb.push_back(e);
        DATA1 = a;
        DATA2 = b;
        START = 1'b1;
        tick();
        t_since = 0;
        START = 1'b0;
    endtask

    task automatic collect(input string tag);
        exp_t e;
        bit got;
        got = 1'b0;
        for (int c = 0; c < 16 && !got; c++) begin
            tick();
            if (DONE === 1'b1) got = 1'b1;
            else chk({tag, "_busy"}, 32'(BUSY), 32'd1);
        end
        if (!got) begin
            chk({tag, "_timeout"}, 32'(DONE), 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk({tag, "_lat"}, 32'(t_since), 32'(e.lat));
            chk({tag, "_q"}, 32'(QUOTIENT), 32'(e.q));
            chk({tag, "_r"}, 32'(REMAINDER), 32'(e.r));
            chk({tag, "_dz"}, 32'(DIVZERO), 32'(e.dz));
            chk({tag, "_busy_at_done"}, 32'(BUSY), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;

        #2 RESET = 1'b0;
        #1;
        chk("rst_q", 32'(QUOTIENT), 32'd0);
        chk("rst_r", 32'(REMAINDER), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_dz", 32'(DIVZERO), 32'd0);
        tick();
        tick();
        RESET = 1'b1;

        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
        chk("d100_busy_t0", 32'(BUSY), 32'd1);
        collect("d100");
        tick();
        chk("d100_done_pulse", 32'(DONE), 32'd0);
        chk("d100_hold_q", 32'(QUOTIENT), 32'd14);

        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
        collect("d255");
        issue(8'd3, 8'd10, 8'd0, 8'd3, 1'b0, 9);
        chk("b2b_busy", 32'(BUSY), 32'd1);
        chk("b2b_done_low", 32'(DONE), 32'd0);
        collect("d3");

        issue(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1);
        collect("dz5");
        tick();
        chk("dz_hold", 32'(DIVZERO), 32'd1);
        issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9);
        chk("dz_clear", 32'(DIVZERO), 32'd0);
        collect("d9");

        issue(8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 9);
        tick();
        tick();
        START = 1'b1;
        DATA1 = 8'd7;
        DATA2 = 8'd3;
        tick();
        START = 1'b0;
        chk("mid_busy", 32'(BUSY), 32'd1);
        collect("mid");

        issue(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 9);
        tick();
        tick();
        tick();
        tick();
        RESET = 1'b0;
        #1;
        chk("arst_q", 32'(QUOTIENT), 32'd0);
        chk("arst_r", 32'(REMAINDER), 32'd0);
        chk("arst_busy", 32'(BUSY), 32'd0);
        chk("arst_done", 32'(DONE), 32'd0);
        chk("arst_dz", 32'(DIVZERO), 32'd0);
        void'(sb.pop_back());
        tick();
        RESET = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("arst_no_done", 32'(DONE), 32'd0);
        end
        issue(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9);
        collect("d50");

        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            issue(a, b, a / b, a % b, 1'b0, 9);
            collect("rnd");
        end

`ifdef DIV_SIGNED_EN
        SIGNED = 1'b1;
        issue(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 10);
        collect("s_m7_2");
        issue(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10);
        collect("s_m128_m1");
        SIGNED = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/divmodule.md
DIVMODULE -- requirements
Module: divmodule

Interface
REQ-001 SHALL have clock and reset as its first two ports: CLK, input, 1 bit, rising-edge clock; RESET, input, 1 bit, asynchronous active-low reset.
REQ-002 SHALL have START, input, 1 bit: a request to begin a division, sampled on the CLK rising edge.
REQ-003 SHALL have DATA1, input, 8 bits: the dividend.
REQ-004 SHALL have DATA2, input, 8 bits: the divisor.
REQ-005 SHALL have QUOTIENT, output, 8 bits, registered.
REQ-006 SHALL have REMAINDER, output, 8 bits, registered.
REQ-007 SHALL have BUSY, output, 1 bit, registered: a division is in progress.
REQ-008 SHALL have DONE, output, 1 bit, registered: a one-cycle pulse marking a valid result.
REQ-009 SHALL have DIVZERO, output, 1 bit, registered: the last result came from a divisor of 0.
REQ-010 SHALL have SIGNED, input, 1 bit, present only when DIV_SIGNED_EN is defined: selects two's-complement operation.

Function
REQ-011 SHALL implement the FSM states IDLE, CALC, FIX and FINISH.
REQ-012 SHALL accept START only in IDLE or FINISH; START is ignored while BUSY=1.
REQ-013 On an accepted START at edge t0, SHALL latch DATA1, DATA2 and SIGNED, set BUSY=1 and enter CALC; later operand changes have no effect.
REQ-014 CALC SHALL use restoring shift-subtract, one quotient bit per cycle, MSB first, for exactly 8 cycles; a 4-bit counter tracks progress.
REQ-015 For unsigned operation, at edge t9 SHALL register QUOTIENT and REMAINDER, pulse DONE=1, clear BUSY and enter FINISH.
REQ-016 SHALL leave FINISH for IDLE after one cycle, or re-enter CALC if START=1 in that cycle, allowing back-to-back operations.
REQ-017 If the latched divisor is 0, at edge t1 SHALL set QUOTIENT=8'hFF, REMAINDER=dividend, DIVZERO=1 and DONE=1, skipping CALC.
REQ-018 SHALL clear DIVZERO on the next accepted START whose divisor is nonzero.
REQ-019 SHALL hold QUOTIENT, REMAINDER and DIVZERO unchanged between completions.
REQ-020 SHALL drive DONE high for exactly one cycle per operation and never while BUSY=1.
REQ-021 SHALL satisfy unsigned results with QUOTIENT*DATA2+REMAINDER=DATA1 and REMAINDER<DATA2.

Reset
REQ-022 RESET=0 SHALL asynchronously force state=IDLE, the counter to 0, and QUOTIENT, REMAINDER, BUSY, DONE and DIVZERO to 0.
REQ-023 RESET asserted during CALC or FIX SHALL abort the operation with no DONE pulse.
REQ-024 After RESET deasserts, SHALL accept START from the first rising edge.

Configuration
REQ-025 SHALL compile the SIGNED port and the FIX state only when DIV_SIGNED_EN is defined.
REQ-026 With DIV_SIGNED_EN defined and SIGNED=1, SHALL divide operand magnitudes in CALC and then spend one FIX cycle applying signs.
REQ-027 In FIX, quotient sign SHALL be the XOR of the operand signs and remainder sign SHALL follow the dividend; quotient truncates toward zero.
REQ-028 With DIV_SIGNED_EN defined and SIGNED=1, DONE SHALL arrive at t10 instead of t9.
REQ-029 With DIV_SIGNED_EN defined, the signed case -128/-1 SHALL produce QUOTIENT=8'h80 and REMAINDER=0 (wrap, no flag).
REQ-030 Without DIV_SIGNED_EN, SHALL have no SIGNED port and no FIX state, and all operation SHALL be unsigned.

Verification
REQ-031 Bench SHALL cover 100/7 with START at t0 -> QUOTIENT=14, REMAINDER=2, DONE at t9, BUSY high during t1..t8.
REQ-032 Bench SHALL cover 255/1 then 3/10 back-to-back, with START in the FINISH cycle -> results 255 R0, then 0 R3, with no idle cycle between operations.
REQ-033 Bench SHALL cover 5/0 -> DONE at t1 with QUOTIENT=8'hFF, REMAINDER=5, DIVZERO=1; a following 9/3 -> 3 R0 with DIVZERO=0.
REQ-034 Bench SHALL cover START pulsed again and DATA1/DATA2 changed mid-CALC -> both ignored, and the original result is delivered.
REQ-035 Bench SHALL cover RESET=0 at t4 of 200/3 -> all outputs 0 immediately, no DONE pulse, and a new 50/5 -> 10 R0 after reset deasserts.
REQ-036 Bench SHALL cover, with DIV_SIGNED_EN defined, -7/2 (F9/02) -> QUOTIENT=FD, REMAINDER=FF at t10, and -128/-1 -> QUOTIENT=80, REMAINDER=00.
